// File: rtl/mcpu_wb_sequencer.sv
// rtl/mcpu_wb_sequencer.sv - register-file writeback sequencer (IDLE/MEMREQ/SETUP/STROBE/HOLD)
// Optional load-acknowledge timeout: define MCPU_WB_SEQUENCER_TIMEOUT_EN.
module mcpu_wb_sequencer #(
    parameter int WORD_SIZE      = 8,
    parameter int OPERAND_SIZE   = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [1:0]              instr_class,
    input  logic [OPERAND_SIZE-1:0] dst,
    input  logic [WORD_SIZE-1:0]    alu_result,
    output logic                    mem_req,
    input  logic                    mem_ack,
    input  logic [WORD_SIZE-1:0]    mem_data,
    output logic [OPERAND_SIZE-1:0] op1,
    output logic [WORD_SIZE-1:0]    datatoload,
    output logic [1:0]              regsetcmd,
    output logic                    regsetwb,
    output logic                    wb_done,
    output logic                    err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEMREQ,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_MOV = 2'b01;
    localparam logic [1:0] CLS_LOAD = 2'b10;

    localparam logic [1:0] CMD_NORMAL_EX = 2'b00;
    localparam logic [1:0] CMD_MOV_INTERNAL = 2'b01;
    localparam logic [1:0] CMD_LOAD_FROM_DATA = 2'b10;
    localparam logic [1:0] CMD_DO_NOTHING = 2'b11;

    state_t                  state_q, state_d;
    logic [OPERAND_SIZE-1:0] dst_q, dst_d;
    logic [OPERAND_SIZE-1:0] op1_q, op1_d;
    logic [WORD_SIZE-1:0]    data_q, data_d;
    logic [1:0]              cmd_q, cmd_d;
    logic                    regsetwb_q, wb_done_q, wb_done_d, mem_req_q;
    logic                    timeout;

`ifdef MCPU_WB_SEQUENCER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    // cnt_q holds the number of MEMREQ cycles already completed
    assign timeout = (state_q == S_MEMREQ) && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !mem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == S_MEMREQ && state_d == S_MEMREQ) ? cnt_q + CW'(1) : '0;
            err_q <= timeout;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        op1_d     = op1_q;
        data_d    = data_q;
        cmd_d     = cmd_q;
        wb_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_d = CMD_DO_NOTHING;
                if (instr_valid) begin
                    dst_d = dst;
                    case (instr_class)
                        CLS_ALU: begin
                            state_d = S_SETUP;
                            op1_d   = dst;
                            data_d  = alu_result;
                            cmd_d   = CMD_NORMAL_EX;
                        end
                        CLS_MOV: begin
                            state_d = S_SETUP;
                            op1_d   = dst;
                            data_d  = '0;
                            cmd_d   = CMD_MOV_INTERNAL;
                        end
                        CLS_LOAD: state_d = S_MEMREQ;
                        default:  wb_done_d = 1'b1;
                    endcase
                end
            end
            S_MEMREQ: begin
                if (mem_ack) begin
                    state_d = S_SETUP;
                    op1_d   = dst_q;
                    data_d  = mem_data;
                    cmd_d   = CMD_LOAD_FROM_DATA;
                end else if (timeout) begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                state_d = S_IDLE;
                cmd_d   = CMD_DO_NOTHING;
            end
            default: begin
                state_d = S_IDLE;
                cmd_d   = CMD_DO_NOTHING;
            end
        endcase
        if (state_d == S_HOLD) wb_done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            dst_q      <= '0;
            op1_q      <= '0;
            data_q     <= '0;
            cmd_q      <= CMD_DO_NOTHING;
            regsetwb_q <= 1'b0;
            wb_done_q  <= 1'b0;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dst_q      <= dst_d;
            op1_q      <= op1_d;
            data_q     <= data_d;
            cmd_q      <= cmd_d;
            regsetwb_q <= (state_d == S_STROBE);
            wb_done_q  <= wb_done_d;
            mem_req_q  <= (state_d == S_MEMREQ);
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign mem_req     = mem_req_q;
    assign op1         = op1_q;
    assign datatoload  = data_q;
    assign regsetcmd   = cmd_q;
    assign regsetwb    = regsetwb_q;
    assign wb_done     = wb_done_q;

endmodule

// File: tb/tb_mcpu_wb_sequencer.sv
// tb/tb_mcpu_wb_sequencer.sv - directed self-checking bench for mcpu_wb_sequencer
module tb_mcpu_wb_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [1:0] instr_class = 2'b11;
    logic [3:0] dst = '0;
    logic [7:0] alu_result = '0;
    logic       mem_req;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_data = '0;
    logic [3:0] op1;
    logic [7:0] datatoload;
    logic [1:0] regsetcmd;
    logic       regsetwb;
    logic       wb_done;
    logic       err;

    int n_checks = 0;
    int n_fail = 0;
    int wb_edges = 0;
    int snap;
    int req_cycles;

    always #5 clk = ~clk;
    always @(posedge regsetwb) wb_edges++;

    mcpu_wb_sequencer #(
        .WORD_SIZE(8),
        .OPERAND_SIZE(4),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_class(instr_class),
        .dst(dst),
        .alu_result(alu_result),
        .mem_req(mem_req),
        .mem_ack(mem_ack),
        .mem_data(mem_data),
        .op1(op1),
        .datatoload(datatoload),
        .regsetcmd(regsetcmd),
        .regsetwb(regsetwb),
        .wb_done(wb_done),
        .err(err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] cls, input logic [3:0] d, input logic [7:0] alu);
        instr_valid = 1'b1;
        instr_class = cls;
        dst         = d;
        alu_result  = alu;
    endtask

    initial begin
        // reset state
        step();
        step();
        check("rst_ready", instr_ready, 1);
        check("rst_wb", regsetwb, 0);
        check("rst_cmd", regsetcmd, 2'b11);
        check("rst_op1", op1, 0);
        check("rst_data", datatoload, 0);
        check("rst_memreq", mem_req, 0);
        check("rst_done", wb_done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        step();

        // ALU dst=5 result A7
        snap = wb_edges;
        offer(2'b00, 4'd5, 8'hA7);
        step();
        instr_valid = 1'b0;
        alu_result  = 8'h00;
        check("alu_setup_ready", instr_ready, 0);
        check("alu_setup_op1", op1, 5);
        check("alu_setup_cmd", regsetcmd, 2'b00);
        check("alu_setup_data", datatoload, 8'hA7);
        check("alu_setup_wb", regsetwb, 0);
        step();
        check("alu_strobe_wb", regsetwb, 1);
        check("alu_strobe_done", wb_done, 0);
        check("alu_strobe_data", datatoload, 8'hA7);
        step();
        check("alu_hold_wb", regsetwb, 0);
        check("alu_hold_done", wb_done, 1);
        check("alu_hold_ready", instr_ready, 0);
        check("alu_hold_cmd", regsetcmd, 2'b00);
        step();
        check("alu_idle_ready", instr_ready, 1);
        check("alu_idle_done", wb_done, 0);
        check("alu_idle_cmd", regsetcmd, 2'b11);
        check("alu_idle_op1", op1, 5);
        check("alu_idle_data", datatoload, 8'hA7);
        check("alu_edges", wb_edges - snap, 1);

        // MOV dst=3 with instr_valid held high
        snap = wb_edges;
        offer(2'b01, 4'd3, 8'hFF);
        step();
        check("mov_cmd", regsetcmd, 2'b01);
        check("mov_op1", op1, 3);
        check("mov_data", datatoload, 0);
        step();
        check("mov_strobe", regsetwb, 1);
        step();
        check("mov_hold_ready", instr_ready, 0);
        check("mov_hold_done", wb_done, 1);
        step();
        check("mov_idle_ready", instr_ready, 1);
        check("mov_idle_cmd", regsetcmd, 2'b11);
        check("mov_one_edge", wb_edges - snap, 1);
        step();
        instr_valid = 1'b0;
        check("mov_reaccept_cmd", regsetcmd, 2'b01);
        check("mov_reaccept_ready", instr_ready, 0);
        step();
        step();
        step();
        check("mov_reaccept_edges", wb_edges - snap, 2);
        check("mov_end_ready", instr_ready, 1);

        // LOAD dst=9, ack after 4 MEMREQ cycles with 3C
        snap = wb_edges;
        req_cycles = 0;
        offer(2'b10, 4'd9, 8'h11);
        step();
        instr_valid = 1'b0;
        check("ld_ready", instr_ready, 0);
        check("ld_cmd_wait", regsetcmd, 2'b11);
        for (int i = 0; i < 4; i++) begin
            if (mem_req) req_cycles++;
            if (i == 3) begin
                mem_ack  = 1'b1;
                mem_data = 8'h3C;
            end
            step();
        end
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        check("ld_req_cycles", req_cycles, 4);
        check("ld_req_drop", mem_req, 0);
        check("ld_cmd", regsetcmd, 2'b10);
        check("ld_data", datatoload, 8'h3C);
        check("ld_op1", op1, 9);
        step();
        check("ld_strobe", regsetwb, 1);
        step();
        check("ld_done", wb_done, 1);
        step();
        check("ld_idle_ready", instr_ready, 1);
        check("ld_edges", wb_edges - snap, 1);

        // NOP
        snap = wb_edges;
        offer(2'b11, 4'd7, 8'h22);
        step();
        instr_valid = 1'b0;
        check("nop_done", wb_done, 1);
        check("nop_ready", instr_ready, 1);
        check("nop_cmd", regsetcmd, 2'b11);
        check("nop_op1_kept", op1, 9);
        step();
        check("nop_done_clear", wb_done, 0);
        check("nop_ready2", instr_ready, 1);
        check("nop_edges", wb_edges - snap, 0);

        // LOAD with no acknowledge
        snap = wb_edges;
        offer(2'b10, 4'd4, 8'h00);
        step();
        instr_valid = 1'b0;
`ifdef MCPU_WB_SEQUENCER_TIMEOUT_EN
        for (int i = 1; i < 15; i++) step();
        check("to_req_last", mem_req, 1);
        check("to_err_early", err, 0);
        step();
        check("to_err", err, 1);
        check("to_req_drop", mem_req, 0);
        check("to_ready", instr_ready, 1);
        step();
        check("to_err_clear", err, 0);
        check("to_done", wb_done, 0);
        check("to_edges", wb_edges - snap, 0);

        // ack in expiry cycle wins
        offer(2'b10, 4'd6, 8'h00);
        step();
        instr_valid = 1'b0;
        for (int i = 1; i < 15; i++) step();
        mem_ack  = 1'b1;
        mem_data = 8'h5A;
        step();
        mem_ack = 1'b0;
        check("race_err", err, 0);
        check("race_cmd", regsetcmd, 2'b10);
        check("race_data", datatoload, 8'h5A);
        step();
        step();
        step();
        check("race_edges", wb_edges - snap, 1);
`else
        for (int i = 0; i < 20; i++) step();
        check("noto_req", mem_req, 1);
        check("noto_err", err, 0);
        check("noto_ready", instr_ready, 0);
        mem_ack  = 1'b1;
        mem_data = 8'h5A;
        step();
        mem_ack = 1'b0;
        check("noto_cmd", regsetcmd, 2'b10);
        step();
        step();
        step();
        check("noto_edges", wb_edges - snap, 1);
`endif

        // asynchronous reset during STROBE
        offer(2'b00, 4'd2, 8'h55);
        step();
        instr_valid = 1'b0;
        step();
        check("ar_strobe", regsetwb, 1);
        snap = wb_edges;
        rst_n = 1'b0;
        #1;
        check("ar_wb", regsetwb, 0);
        check("ar_cmd", regsetcmd, 2'b11);
        check("ar_op1", op1, 0);
        check("ar_ready", instr_ready, 1);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("ar_no_edge", wb_edges - snap, 0);
        check("ar_done", wb_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
